// File: rtl/trap_monitor.sv
// ============================================================================
//  Module   : trap_monitor
//  Purpose  : End-of-test authority beside the core's writeback stage. Watches
//             the commit stream, checks RV32I legality, grades ebreak by the
//             a0 exit code, runs a no-commit watchdog, optionally traps on
//             ALU overflow, counts retirements and keeps a PC history ring.
//  Ports    : clk, rst (async, active-low)
//             commit_valid, pc, instruction, a0, overflow  - commit stream
//             hist_idx / hist_pc                           - history read port
//             halted, trap_good, trap_bad, trap_cause,
//             trap_pc, retire_cnt                          - trap status
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module trap_monitor #(
   parameter int XLEN        = 32,
   parameter int CNT_W       = 32,
   parameter int TIMEOUT     = 100000,
   parameter int HIST_DEPTH  = 8,
   parameter int TRAP_ON_OVF = 0,
   parameter int ZICSR       = 0,
   parameter int SIM_FINISH  = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          commit_valid,
   input  logic [XLEN-1:0]               pc,
   input  logic [31:0]                   instruction,
   input  logic [XLEN-1:0]               a0,
   input  logic                          overflow,
   input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
   output logic                          halted,
   output logic                          trap_good,
   output logic                          trap_bad,
   output logic [2:0]                    trap_cause,
   output logic [XLEN-1:0]               trap_pc,
   output logic [CNT_W-1:0]              retire_cnt,
   output logic [XLEN-1:0]               hist_pc
);

   localparam int HW   = $clog2(HIST_DEPTH);
   // Watchdog only needs to hold TIMEOUT-1; it traps before wrapping.
   localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [1:0] ST_RUN  = 2'd0;
   localparam logic [1:0] ST_FIN  = 2'd1;   // halted, simulation finish pending
   localparam logic [1:0] ST_HALT = 2'd2;

   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] ECALL  = 32'h0000_0073;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [WD_W-1:0]  wd_q;
   logic [HW-1:0]    wp_q;
   logic [XLEN-1:0]  ring_q [HIST_DEPTH];
   logic [XLEN-1:0]  last_pc_q;
   logic [XLEN-1:0]  trap_pc_q;
   logic [2:0]       cause_q;

   logic             legal;
   logic             run;
   logic             wd_expire;
   logic [2:0]       cause_d;
   logic [HW-1:0]    rd_idx;

   wire [6:0] opc = instruction[6:0];
   wire [2:0] f3  = instruction[14:12];
   wire [6:0] f7  = instruction[31:25];

   // ------------------------------------------------------------------------
   // RV32I legality decode
   // ------------------------------------------------------------------------
   always_comb begin
      legal = 1'b0;
      case (opc)
         7'b0110111, 7'b0010111, 7'b1101111, 7'b0001111: legal = 1'b1;
         7'b1100111: legal = (f3 == 3'b000);
         7'b1100011: legal = (f3 != 3'b010) && (f3 != 3'b011);
         7'b0000011: legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
         7'b0100011: legal = (f3 <= 3'b010);
         7'b0010011: begin
            if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
            else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
            else                   legal = 1'b1;
         end
         7'b0110011: legal = (f7 == 7'b0000000) ||
                             ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
         7'b1110011: begin
            if (f3 == 3'b000) legal = (instruction == ECALL) || (instruction == EBREAK);
            else              legal = (ZICSR != 0) && (f3 != 3'b100);
         end
         default: legal = 1'b0;
      endcase
   end

   assign run       = (state_q == ST_RUN);
   assign wd_expire = (TIMEOUT > 0) && (wd_q == WD_W'(TIMEOUT - 1));

   // Trap cause for this edge; a commit always pre-empts the watchdog.
   always_comb begin
      cause_d = 3'd0;
      if (run && commit_valid) begin
         if (!legal)                                 cause_d = 3'd3;
         else if (instruction == EBREAK)             cause_d = (a0 == '0) ? 3'd1 : 3'd2;
         else if ((TRAP_ON_OVF != 0) && overflow)    cause_d = 3'd5;
      end else if (run && wd_expire) begin
         cause_d = 3'd4;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: state register / next state / outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_RUN;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:  if (cause_d != 3'd0) state_d = (SIM_FINISH != 0) ? ST_FIN : ST_HALT;
         ST_FIN:  state_d = ST_HALT;
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_HALT;
      endcase
   end

   always_comb begin
      halted = (state_q != ST_RUN);
   end

   // ------------------------------------------------------------------------
   // Datapath: counters, ring, trap capture (all frozen once halted)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         wd_q      <= '0;
         wp_q      <= '0;
         last_pc_q <= '0;
         trap_pc_q <= '0;
         cause_q   <= 3'd0;
         for (int i = 0; i < HIST_DEPTH; i++) ring_q[i] <= '0;
      end else if (run) begin
         if (commit_valid) begin
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            ring_q[wp_q] <= pc;
            wp_q         <= wp_q + 1'b1;
            wd_q         <= '0;
            last_pc_q    <= pc;
         end else if (TIMEOUT > 0) begin
            wd_q <= wd_q + 1'b1;
         end
         if (cause_d != 3'd0) begin
            cause_q   <= cause_d;
            trap_pc_q <= commit_valid ? pc : last_pc_q;
         end
      end
   end

   // Most recent commit sits one slot behind the write pointer.
   assign rd_idx     = wp_q - HW'(1) - hist_idx;
   assign hist_pc    = ring_q[rd_idx];
   assign trap_cause = cause_q;
   assign trap_pc    = trap_pc_q;
   assign retire_cnt = cnt_q;
   assign trap_good  = halted && (cause_q == 3'd1);
   assign trap_bad   = halted && (cause_q >= 3'd2);

   // ------------------------------------------------------------------------
   // Simulation end-of-test banner
   // ------------------------------------------------------------------------
   generate
      if (SIM_FINISH != 0) begin : g_finish
`ifndef SYNTHESIS
         logic [31:0]     ins_s;
         logic [XLEN-1:0] a0_s;
         always @(posedge clk) begin
            if (run && commit_valid && (cause_d != 3'd0)) begin
               ins_s <= instruction;
               a0_s  <= a0;
            end
            if (state_q == ST_FIN) begin
               $display("trap_monitor: cause=%0d trap_pc=%h instr=%h a0=%h retired=%0d",
                        cause_q, trap_pc_q, ins_s, a0_s, cnt_q);
               if (cause_q == 3'd1) $finish(0);
               else                 $finish(1);
            end
         end
`endif
      end
   endgenerate

endmodule

`default_nettype wire
